// File: rtl/approx_mul_pipe.sv
// Pipelined W x W unsigned multiplier with a per-beat exact / column-truncated mode.
// Global-stall valid/ready pipeline: every stage advances together whenever the output slot frees.
module approx_mul_pipe #(
    parameter int unsigned W      = 12,
    parameter int unsigned TRUNC  = 15,
    parameter int unsigned STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic             out_approx
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned NS = STAGES - 1;
    // Partial-product rows folded into the running sum per stage boundary.
    localparam int unsigned CH = (W + NS - 1) / NS;

    // Rows [s*CH, s*CH+CH) of the partial-product array. In approximate mode each row
    // keeps only bits landing in columns >= TRUNC, so the low TRUNC sum bits stay zero.
    function automatic logic [PW-1:0] chunk_sum(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         approx,
        input int unsigned  s
    );
        logic [PW-1:0] sum;
        logic [W-1:0]  keep;
        logic [W-1:0]  bsh;
        sum = '0;
        for (int unsigned j = 0; j < W; j++) begin
            bsh = b >> j;
            if (j >= s * CH && j < (s + 1) * CH && bsh[0]) begin
                keep = '1;
                if (approx && TRUNC > j) begin
                    keep = keep << (TRUNC - j);
                end
                sum = sum + ({{W{1'b0}}, a & keep} << j);
            end
        end
        return sum;
    endfunction

    logic [W-1:0]  a_q   [NS];
    logic [W-1:0]  a_d   [NS];
    logic [W-1:0]  b_q   [NS];
    logic [W-1:0]  b_d   [NS];
    logic          m_q   [NS];
    logic          m_d   [NS];
    logic          v_q   [NS];
    logic          v_d   [NS];
    logic [PW-1:0] acc_q [NS];
    logic [PW-1:0] acc_d [NS];

    logic [PW-1:0] out_p_q;
    logic [PW-1:0] out_p_d;
    logic          out_approx_q;
    logic          out_valid_q;
    logic          advance;

    assign advance    = out_ready | ~out_valid_q;
    assign in_ready   = advance;
    assign out_valid  = out_valid_q;
    assign out_p      = out_p_q;
    assign out_approx = out_approx_q;

    always_comb begin
        a_d[0]   = in_a;
        b_d[0]   = in_b;
        m_d[0]   = in_approx;
        v_d[0]   = in_valid;
        acc_d[0] = '0;
        for (int unsigned s = 1; s < NS; s++) begin
            a_d[s]   = a_q[s-1];
            b_d[s]   = b_q[s-1];
            m_d[s]   = m_q[s-1];
            v_d[s]   = v_q[s-1];
            acc_d[s] = acc_q[s-1] + chunk_sum(a_q[s-1], b_q[s-1], m_q[s-1], s - 1);
        end
        out_p_d = acc_q[NS-1] + chunk_sum(a_q[NS-1], b_q[NS-1], m_q[NS-1], NS - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NS; s++) begin
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                m_q[s]   <= 1'b0;
                v_q[s]   <= 1'b0;
                acc_q[s] <= '0;
            end
            out_p_q      <= '0;
            out_approx_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else if (advance) begin
            for (int unsigned s = 0; s < NS; s++) begin
                a_q[s]   <= a_d[s];
                b_q[s]   <= b_d[s];
                m_q[s]   <= m_d[s];
                v_q[s]   <= v_d[s];
                acc_q[s] <= acc_d[s];
            end
            out_p_q      <= out_p_d;
            out_approx_q <= m_q[NS-1];
            out_valid_q  <= v_q[NS-1];
        end
    end

endmodule
